// File: rtl/piso_pkg.sv
// Shared definitions for the MSB-first parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer; tc flags the last data bit (WIDTH-1).
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (enable)
      cnt <= cnt + CW'(1);
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// MSB-first serializer with valid/ready load and gapless back-to-back frames.
// Defining PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             frame_done
);

  piso_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic             tc;
  logic             last_bit;
  logic             accept;
  logic             ready_dec;

  assign last_bit = (state == SHIFT) && tc;

`ifdef PISO_PARITY_EN
  logic par;

  assign ready_dec  = (state == IDLE) || (state == PARITY);
  assign frame_done = (state == PARITY);
  assign sout       = (state == SHIFT)  ? shreg[WIDTH-1] :
                      (state == PARITY) ? par : 1'b0;
`else
  assign ready_dec  = (state == IDLE) || last_bit;
  assign frame_done = last_bit;
  assign sout       = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
`endif

  // Reset must dominate a simultaneous load offer.
  assign load_ready = ready_dec && !rst;
  assign accept     = load_valid && load_ready;
  assign sout_valid = (state != IDLE);
  assign busy       = sout_valid;

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept || last_bit),
    .enable (state == SHIFT),
    .tc     (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
`ifdef PISO_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (accept) begin
      state <= SHIFT;
      shreg <= data_in;
`ifdef PISO_PARITY_EN
      par   <= ^data_in;
`endif
    end else begin
      case (state)
        SHIFT: begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          if (tc) begin
`ifdef PISO_PARITY_EN
            state <= PARITY;
`else
            state <= IDLE;
`endif
          end
        end
        PARITY:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (WIDTH=8); expected bits queued on load.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FW  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FW  = W;
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         frame_done;

  int vectors = 0;
  int miscompares = 0;

  // Each entry: {frame_done, sout}
  logic [1:0] exp_q[$];
  logic [1:0] e;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic push_word(input logic [W-1:0] w);
    for (int k = 0; k < W; k++)
      exp_q.push_back({(k == W - 1) && !PAR, w[W-1-k]});
    if (PAR)
      exp_q.push_back({1'b1, ^w});
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b1; data_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({sout, sout_valid, busy, frame_done, load_ready} !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %b want 00000", i,
                 {sout, sout_valid, busy, frame_done, load_ready});
      end
    end
    rst = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (load_ready !== 1'b1 || sout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: load_ready=%b sout_valid=%b want 1 0",
               load_ready, sout_valid);
    end
  endtask

  task automatic test_single();
    data_in = 8'hB4; load_valid = 1'b1;
    push_word(8'hB4);
    for (int i = 0; i < FW; i++) begin
      @(negedge clk);
      if (i == 0) load_valid = 1'b0;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL single_underflow bit %0d", i);
      end else begin
        e = exp_q.pop_front();
        if ({sout_valid, frame_done, sout} !== {1'b1, e}) begin
          miscompares++;
          $display("FAIL single_bit %0d: got v/fd/s=%b want %b", i,
                   {sout_valid, frame_done, sout}, {1'b1, e});
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (sout_valid !== 1'b0 || busy !== 1'b0 || sout !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end: v=%b busy=%b s=%b want 0 0 0", sout_valid, busy, sout);
    end
  endtask

  task automatic test_back_to_back();
    data_in = 8'hA5; load_valid = 1'b1;
    push_word(8'hA5);
    push_word(8'h3C);
    for (int i = 0; i < 2 * FW; i++) begin
      @(negedge clk);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL b2b_underflow bit %0d", i);
      end else begin
        e = exp_q.pop_front();
        if ({sout_valid, frame_done, sout} !== {1'b1, e}) begin
          miscompares++;
          $display("FAIL b2b_bit %0d: got v/fd/s=%b want %b", i,
                   {sout_valid, frame_done, sout}, {1'b1, e});
        end
        if (i < FW && load_ready !== e[1]) begin
          miscompares++;
          $display("FAIL b2b_ready bit %0d: got %b want %b", i, load_ready, e[1]);
        end
      end
      if (i == 0) data_in = 8'h3C;
      if (i == FW) load_valid = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (sout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: sout_valid=%b want 0", sout_valid);
    end
  endtask

  task automatic test_ignored_load();
    data_in = 8'hB4; load_valid = 1'b1;
    push_word(8'hB4);
    for (int i = 0; i < FW; i++) begin
      @(negedge clk);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL ignored_underflow bit %0d", i);
      end else begin
        e = exp_q.pop_front();
        if ({sout_valid, frame_done, sout} !== {1'b1, e}) begin
          miscompares++;
          $display("FAIL ignored_bit %0d: got v/fd/s=%b want %b", i,
                   {sout_valid, frame_done, sout}, {1'b1, e});
        end
      end
      if (i == 0) load_valid = 1'b0;
      if (i == 3) begin data_in = 8'hFF; load_valid = 1'b1; end
      if (i == 4) load_valid = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (sout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ignored_end: sout_valid=%b want 0", sout_valid);
    end
  endtask

  task automatic test_midframe_reset();
    data_in = 8'h0F; load_valid = 1'b1;
    push_word(8'h0F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) load_valid = 1'b0;
      vectors++;
      e = exp_q.pop_front();
      if ({sout_valid, sout} !== {1'b1, e[0]}) begin
        miscompares++;
        $display("FAIL midrst_bit %0d: got v/s=%b want %b", i, {sout_valid, sout}, {1'b1, e[0]});
      end
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (sout_valid !== 1'b0 || busy !== 1'b0 || sout !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_abort: v=%b busy=%b s=%b want 0 0 0", sout_valid, busy, sout);
    end
    rst = 1'b0;
    exp_q.delete();
    data_in = 8'hFF; load_valid = 1'b1;
    push_word(8'hFF);
    for (int i = 0; i < FW; i++) begin
      @(negedge clk);
      if (i == 0) load_valid = 1'b0;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL midrst_underflow bit %0d", i);
      end else begin
        e = exp_q.pop_front();
        if ({sout_valid, frame_done, sout} !== {1'b1, e} || (i < W && sout !== 1'b1)) begin
          miscompares++;
          $display("FAIL midrst_ff_bit %0d: got v/fd/s=%b want %b", i,
                   {sout_valid, frame_done, sout}, {1'b1, e});
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (sout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_end: sout_valid=%b want 0", sout_valid);
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] words [2];
    logic         pbit  [2];
    words[0] = 8'hB4; pbit[0] = 1'b0;
    words[1] = 8'h07; pbit[1] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      data_in = words[n]; load_valid = 1'b1;
      for (int i = 0; i < FW; i++) begin
        @(negedge clk);
        if (i == 0) load_valid = 1'b0;
        vectors++;
        if (i == W - 1 && (frame_done !== 1'b0 || load_ready !== 1'b0)) begin
          miscompares++;
          $display("FAIL parity_lastdata w%0d: fd=%b rdy=%b want 0 0", n, frame_done, load_ready);
        end
        if (i == W && {sout_valid, frame_done, sout, load_ready} !== {2'b11, pbit[n], 1'b1}) begin
          miscompares++;
          $display("FAIL parity_bit w%0d: got v/fd/s/rdy=%b want %b", n,
                   {sout_valid, frame_done, sout, load_ready}, {2'b11, pbit[n], 1'b1});
        end
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load_valid = 1'b0; data_in = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_ignored_load();
    test_midframe_reset();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
